// File: rtl/stage_sequencer_pkg.sv
// Shared stage encodings and enable decode for the multicycle sequencer.
package stage_sequencer_pkg;

  localparam int STAGE_W = 3;
  localparam int WAIT_W  = 8;

  typedef enum logic [STAGE_W-1:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic exec;
    logic mem;
    logic wb;
  } enables_t;

  // One-hot stage enable for the five working states; everything else is quiet.
  function automatic enables_t stage_enables(state_t s);
    enables_t en;
    en = '0;
    case (s)
      S_FETCH:     en.fetch  = 1'b1;
      S_DECODE:    en.decode = 1'b1;
      S_EXECUTE:   en.exec   = 1'b1;
      S_MEMORY:    en.mem    = 1'b1;
      S_WRITEBACK: en.wb     = 1'b1;
      default:     en        = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Handshake and stage-enable bundle between the sequencer and the datapath.
interface stage_sequencer_if #(
  parameter int CNT_W = 32
);
  import stage_sequencer_pkg::*;

  logic               start;
  logic               halt_req;
  logic               imem_ready;
  logic               mem_read;
  logic               mem_write;
  logic               mem_ready;
  logic               fetch_en;
  logic               decode_en;
  logic               exec_en;
  logic               mem_en;
  logic               mem_req;
  logic               wb_en;
  logic               pc_write;
  logic               busy;
  logic               mem_timeout;
  logic [STAGE_W-1:0] stage;
  logic [CNT_W-1:0]   retired_count;

  modport master (
    input  start, halt_req, imem_ready, mem_read, mem_write, mem_ready,
    output fetch_en, decode_en, exec_en, mem_en, mem_req, wb_en, pc_write,
           busy, mem_timeout, stage, retired_count
  );

  modport slave (
    output start, halt_req, imem_ready, mem_read, mem_write, mem_ready,
    input  fetch_en, decode_en, exec_en, mem_en, mem_req, wb_en, pc_write,
           busy, mem_timeout, stage, retired_count
  );

endinterface

// File: rtl/stage_sequencer_wait_timer.sv
// Counts MEMORY wait cycles; expired flags the last cycle allowed before a fault.
module stage_sequencer_wait_timer
  import stage_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] count;

  // Wait counter: clear has priority over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: one-hot stage enables, memory wait/timeout,
// halt latch and retired-instruction counter.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  stage_sequencer_if.master bus
);

  state_t           state;
  state_t           nxt_state;
  logic             mem_op;
  logic             nxt_op;
  logic             halt_pending;
  logic             halt_set;
  logic             timeout_hit;
  logic             retire;
  logic             expired;
  logic             wait_clear;
  logic             wait_inc;
  enables_t         en_q;
  logic             mem_req;
  logic             busy;
  logic             mem_timeout;
  logic [CNT_W-1:0] retired_count;

  assign wait_clear = (state == S_EXECUTE);
  assign wait_inc   = (state == S_MEMORY) && mem_op && !bus.mem_ready && !expired;

  stage_sequencer_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .inc     (wait_inc),
    .expired (expired)
  );

  // Next-state, memory-op latch value, fault and retire decisions.
  always_comb begin
    nxt_state   = state;
    nxt_op      = mem_op;
    timeout_hit = 1'b0;
    retire      = 1'b0;
    case (state)
      S_IDLE:      if (bus.start) nxt_state = S_FETCH;
      S_FETCH:     if (bus.imem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        nxt_state = S_EXECUTE;
        nxt_op    = bus.mem_read | bus.mem_write;
      end
      S_EXECUTE:   nxt_state = S_MEMORY;
      S_MEMORY: begin
        // ready wins over expiry in the same cycle
        if (!mem_op || bus.mem_ready) begin
          nxt_state = S_WRITEBACK;
        end else if (expired) begin
          nxt_state   = S_ERROR;
          timeout_hit = 1'b1;
        end
      end
      S_WRITEBACK: begin
        retire    = 1'b1;
        nxt_state = halt_pending ? S_IDLE : S_FETCH;
      end
      S_ERROR:     nxt_state = S_ERROR;
      default:     nxt_state = bus.start ? S_FETCH : S_IDLE;
    endcase
  end

  // A halt request only counts once an instruction is in flight or starting.
  assign halt_set = bus.halt_req &&
                    (((state != S_IDLE) && (state != S_ERROR)) ||
                     ((state == S_IDLE) && bus.start));

  // State, latches and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      mem_op        <= 1'b0;
      halt_pending  <= 1'b0;
      en_q          <= '0;
      mem_req       <= 1'b0;
      busy          <= 1'b0;
      mem_timeout   <= 1'b0;
      retired_count <= '0;
    end else begin
      state   <= nxt_state;
      mem_op  <= nxt_op;
      en_q    <= stage_enables(nxt_state);
      mem_req <= (nxt_state == S_MEMORY) && nxt_op;
      busy    <= (nxt_state != S_IDLE) && (nxt_state != S_ERROR);
      if (timeout_hit) mem_timeout <= 1'b1;
      if (retire) retired_count <= retired_count + 1'b1;
      if (nxt_state == S_IDLE) begin
        halt_pending <= 1'b0;
      end else if (halt_set) begin
        halt_pending <= 1'b1;
      end
    end
  end

  assign bus.fetch_en      = en_q.fetch;
  assign bus.decode_en     = en_q.decode;
  assign bus.exec_en       = en_q.exec;
  assign bus.mem_en        = en_q.mem;
  assign bus.wb_en         = en_q.wb;
  assign bus.pc_write      = en_q.wb;
  assign bus.mem_req       = mem_req;
  assign bus.busy          = busy;
  assign bus.mem_timeout   = mem_timeout;
  assign bus.stage         = state;
  assign bus.retired_count = retired_count;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-instruction transaction model builds the
// expected stage trace from fetch wait, memory-op and memory-ready delay.
module tb_stage_sequencer;

  localparam int CNT_W = 4;
  localparam int T     = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_count = 0;
  bit   exp_fault = 1'b0;

  stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

  stage_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the stage alone (plus memory op and fault flag).
  task automatic check_state(input string tag, input int s, input bit op);
    chk({tag, ".stage"},    32'(bus.stage), 32'(s));
    chk({tag, ".fetch"},    32'(bus.fetch_en), 32'(s == 1));
    chk({tag, ".decode"},   32'(bus.decode_en), 32'(s == 2));
    chk({tag, ".exec"},     32'(bus.exec_en), 32'(s == 3));
    chk({tag, ".mem_en"},   32'(bus.mem_en), 32'(s == 4));
    chk({tag, ".mem_req"},  32'(bus.mem_req), 32'(s == 4 && op));
    chk({tag, ".wb"},       32'(bus.wb_en), 32'(s == 5));
    chk({tag, ".pc_write"}, 32'(bus.pc_write), 32'(s == 5));
    chk({tag, ".busy"},     32'(bus.busy), 32'(s >= 1 && s <= 5));
    chk({tag, ".timeout"},  32'(bus.mem_timeout), 32'(exp_fault));
    chk({tag, ".count"},    32'(bus.retired_count), 32'(exp_count % (1 << CNT_W)));
  endtask

  // Play one instruction from FETCH. k = cycles after MEMORY entry until
  // mem_ready; k >= T means it never arrives in time and the block faults.
  task automatic run_instr(input string tag, input int fwait, input bit op,
                           input bit store, input int k, input bit halt_exec,
                           input bit halt_pre);
    for (int i = 0; i <= fwait; i++) begin
      bus.imem_ready = (i == fwait);
      bus.mem_read   = 1'($urandom_range(0, 1));
      bus.mem_write  = 1'($urandom_range(0, 1));
      bus.mem_ready  = 1'($urandom_range(0, 1));
      bus.start      = 1'($urandom_range(0, 1));
      check_state({tag, ".fetch"}, 1, 1'b0);
      tick();
    end
    bus.imem_ready = 1'($urandom_range(0, 1));
    bus.mem_read   = op && !store;
    bus.mem_write  = op && store;
    check_state({tag, ".dec"}, 2, 1'b0);
    tick();
    bus.mem_read   = 1'($urandom_range(0, 1));
    bus.mem_write  = 1'($urandom_range(0, 1));
    bus.halt_req   = halt_exec;
    check_state({tag, ".exe"}, 3, 1'b0);
    tick();
    bus.halt_req   = 1'b0;
    if (!op) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      check_state({tag, ".mem"}, 4, 1'b0);
      tick();
    end else begin
      for (int c = 0; c < T; c++) begin
        bus.mem_ready = (c == k);
        check_state({tag, ".memw"}, 4, 1'b1);
        tick();
        if (c == k) break;
      end
      if (k >= T) begin
        exp_fault = 1'b1;
        bus.mem_ready = 1'b0;
        check_state({tag, ".err"}, 6, 1'b0);
        return;
      end
    end
    bus.mem_ready = 1'($urandom_range(0, 1));
    check_state({tag, ".wb"}, 5, 1'b0);
    tick();
    exp_count = (exp_count + 1) % (1 << CNT_W);
    bus.start = 1'b0;
    if (halt_exec || halt_pre) check_state({tag, ".halted"}, 0, 1'b0);
  endtask

  task automatic start_pulse(input bit with_halt);
    bus.start    = 1'b1;
    bus.halt_req = with_halt;
    tick();
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
  endtask

  initial begin
    bit idle;
    bit together;
    bit hx;
    bus.start = 1'b0; bus.halt_req = 1'b0; bus.imem_ready = 1'b0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    check_state("reset", 0, 1'b0);
    reset = 1'b1;
    tick();
    check_state("idle0", 0, 1'b0);
    tick();
    check_state("idle1", 0, 1'b0);

    // Back-to-back no-memory instructions, 5 cycles each
    start_pulse(1'b0);
    for (int n = 0; n < 3; n++) run_instr("b2b", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("b2b.count3", 32'(bus.retired_count), 32'd3);
    // Load, ready on the 3rd MEMORY cycle, halting afterwards
    run_instr("load3", 0, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    chk("load3.count", 32'(bus.retired_count), 32'd4);

    // Randomized instruction stream; wraps the 4-bit counter
    idle = 1'b1;
    for (int n = 0; n < 30; n++) begin
      together = 1'b0;
      if (idle) begin
        together = ($urandom_range(0, 3) == 0);
        start_pulse(together);
      end
      hx = !together && ($urandom_range(0, 4) == 0);
      run_instr("rand", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, T - 1)), hx, together);
      idle = hx || together;
    end
    if (!idle) run_instr("drain", 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Reset asserted mid-MEMORY with mem_req high
    start_pulse(1'b0);
    bus.imem_ready = 1'b1; check_state("rst.f", 1, 1'b0); tick();
    bus.mem_read = 1'b1;   check_state("rst.d", 2, 1'b0); tick();
    bus.mem_read = 1'b0;   check_state("rst.e", 3, 1'b0); tick();
    bus.mem_ready = 1'b0;  check_state("rst.m", 4, 1'b1);
    #2 reset = 1'b0;
    #1;
    exp_count = 0;
    check_state("rst.async", 0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_state("rst.after", 0, 1'b0);

    // start and halt_req together: exactly one instruction
    start_pulse(1'b1);
    run_instr("one", 1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    chk("one.count", 32'(bus.retired_count), 32'd1);
    tick();
    check_state("one.stay", 0, 1'b0);

    // Store with mem_ready held low -> timeout fault, start ignored afterwards
    start_pulse(1'b0);
    run_instr("tmo", 0, 1'b1, 1'b1, T, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1;
      bus.halt_req = 1'($urandom_range(0, 1));
      tick();
      check_state("tmo.stuck", 6, 1'b0);
    end
    bus.start = 1'b0;
    bus.halt_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
